// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment scan decoder.
// Segment patterns are active-low abcdefg, matching CX[7:1].
package seg_scan_decoder_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        DWELL = 1'b1
    } state_e;

    localparam logic [7:0] AN_POS0 = 8'b1111_1110;
    localparam logic [7:0] AN_POS1 = 8'b1111_1101;
    localparam logic [7:0] AN_POS2 = 8'b1111_1011;
    localparam logic [7:0] AN_POS3 = 8'b1111_0111;

    localparam logic [3:0] DIGIT_MAX_UPPER = 4'd5;

    localparam logic [6:0] SEG_PATTERN [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic logic an_is_pos(input logic [7:0] an);
        logic ok;
        case (an)
            AN_POS0, AN_POS1, AN_POS2, AN_POS3: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] an_pos_idx(input logic [7:0] an);
        logic [1:0] idx;
        case (an)
            AN_POS3: idx = 2'd3;
            AN_POS2: idx = 2'd2;
            AN_POS1: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // x*10 as shift-and-add; upper digit is range-checked so 6 bits never overflow
    function automatic logic [5:0] bcd_pair_to_bin(input logic [3:0] hi, input logic [3:0] lo);
        logic [5:0] h;
        h = {2'b00, hi};
        return (h << 3) + (h << 1) + {2'b00, lo};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational active-low 7-segment to BCD decoder; flags any non-digit pattern.
module seg7_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       valid
);

    // Exact-match lookup against the ten legal digit glyphs
    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (seg_n)
            SEG_PATTERN[0]: bcd = 4'd0;
            SEG_PATTERN[1]: bcd = 4'd1;
            SEG_PATTERN[2]: bcd = 4'd2;
            SEG_PATTERN[3]: bcd = 4'd3;
            SEG_PATTERN[4]: bcd = 4'd4;
            SEG_PATTERN[5]: bcd = 4'd5;
            SEG_PATTERN[6]: bcd = 4'd6;
            SEG_PATTERN[7]: bcd = 4'd7;
            SEG_PATTERN[8]: bcd = 4'd8;
            SEG_PATTERN[9]: bcd = 4'd9;
            default:        valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples the multiplexed AN/CX display bus, debounces each digit, and rebuilds
// complete MM:SS frames into binary minutes/seconds.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        resetSW,
    input  logic [7:0]  AN,
    input  logic [7:0]  CX,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        scan_lost
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES);

    logic [15:0]   in_q, in_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_e        state_q, state_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   store_q, store_d;
    logic [3:0]    dp_store_q, dp_store_d;
    logic [5:0]    minutes_q, minutes_d, seconds_q, seconds_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    dp_mask_q, dp_mask_d;
    logic          frame_valid_q, frame_valid_d;
    logic          seg_err_q, seg_err_d;
    logic          scan_lost_q, scan_lost_d;

    logic          sample_same, pos_ok, accept, frame_done, upper_ok;
    logic [1:0]    pos_idx;
    logic [3:0]    dec_bcd;
    logic          dec_ok;

    seg7_to_bcd u_seg7_to_bcd (
        .seg_n (in_q[7:1]),
        .bcd   (dec_bcd),
        .valid (dec_ok)
    );

    // Stability filter, accept FSM, frame assembly and scan timeout
    always_comb begin
        in_d          = {AN, CX};
        sample_same   = (in_d == in_q);
        pos_ok        = an_is_pos(in_q[15:8]);
        pos_idx       = an_pos_idx(in_q[15:8]);
        accept        = (state_q == HUNT) && pos_ok && (stab_cnt_q == STAB_LAST);
        frame_done    = (mask_q == 4'b1111);
        upper_ok      = (store_q[15:12] <= DIGIT_MAX_UPPER) && (store_q[7:4] <= DIGIT_MAX_UPPER);
        stab_cnt_d    = '0;
        state_d       = state_q;
        store_d       = store_q;
        dp_store_d    = dp_store_q;
        minutes_d     = minutes_q;
        seconds_d     = seconds_q;
        digits_d      = digits_q;
        dp_mask_d     = dp_mask_q;
        mask_d        = frame_done ? 4'b0000 : mask_q;

        if (an_is_pos(AN) && sample_same) begin
            stab_cnt_d = (stab_cnt_q == STAB_LAST) ? stab_cnt_q : stab_cnt_q + SW'(1);
        end else begin
            stab_cnt_d = '0;
        end

        case (state_q)
            HUNT:    state_d = accept ? DWELL : HUNT;
            DWELL:   state_d = sample_same ? DWELL : HUNT;
            default: state_d = HUNT;
        endcase

        if (accept && dec_ok) begin
            store_d[{pos_idx, 2'b00} +: 4] = dec_bcd;
            dp_store_d[pos_idx]            = ~in_q[0];
            mask_d[pos_idx]                = 1'b1;
            tmo_d                          = '0;
        end else begin
            tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TW'(1);
        end

        // A bad glyph discards the frame; it also overrides a coincident good completion
        seg_err_d     = (accept && !dec_ok) || (frame_done && !upper_ok);
        frame_valid_d = frame_done && upper_ok && !seg_err_d;
        scan_lost_d   = (tmo_d == TMO_LAST);

        if ((accept && !dec_ok) || scan_lost_d) begin
            mask_d = 4'b0000;
        end else begin
            mask_d = mask_d;
        end

        if (frame_valid_d) begin
            minutes_d = bcd_pair_to_bin(store_q[15:12], store_q[11:8]);
            seconds_d = bcd_pair_to_bin(store_q[7:4], store_q[3:0]);
            digits_d  = store_q;
            dp_mask_d = dp_store_q;
        end else begin
            minutes_d = minutes_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (resetSW) begin
            in_q          <= 16'h0000;
            stab_cnt_q    <= '0;
            tmo_q         <= '0;
            state_q       <= HUNT;
            mask_q        <= 4'b0000;
            store_q       <= 16'h0000;
            dp_store_q    <= 4'b0000;
            minutes_q     <= 6'd0;
            seconds_q     <= 6'd0;
            digits_q      <= 16'h0000;
            dp_mask_q     <= 4'b0000;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            scan_lost_q   <= 1'b0;
        end else begin
            in_q          <= in_d;
            stab_cnt_q    <= stab_cnt_d;
            tmo_q         <= tmo_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            store_q       <= store_d;
            dp_store_q    <= dp_store_d;
            minutes_q     <= minutes_d;
            seconds_q     <= seconds_d;
            digits_q      <= digits_d;
            dp_mask_q     <= dp_mask_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            scan_lost_q   <= scan_lost_d;
        end
    end

    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign digits      = digits_q;
    assign dp_mask     = dp_mask_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        resetSW;
    logic [7:0]  AN, CX;
    logic [5:0]  minutes, seconds;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        frame_valid, seg_err, scan_lost;

    int checks = 0;
    int passes = 0;
    int fv_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .resetSW     (resetSW),
        .AN          (AN),
        .CX          (CX),
        .minutes     (minutes),
        .seconds     (seconds),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .scan_lost   (scan_lost)
    );

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
        if (seg_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    function automatic logic [7:0] cx(input int d, input logic dp);
        logic [6:0] s;
        case (d)
            0: s = 7'b0000001;
            1: s = 7'b1001111;
            2: s = 7'b0010010;
            3: s = 7'b0000110;
            4: s = 7'b1001100;
            5: s = 7'b0100100;
            6: s = 7'b0100000;
            7: s = 7'b0001111;
            8: s = 7'b0000000;
            default: s = 7'b0000100;
        endcase
        return {s, ~dp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [7:0] an, input logic [7:0] c, input int hold, input int gap);
        AN = an;
        CX = c;
        repeat (hold) cyc();
        AN = 8'hFF;
        CX = 8'hFF;
        repeat (gap) cyc();
    endtask

    task automatic check_outputs(input string tag, input logic [5:0] m, input logic [5:0] s,
                                 input logic [15:0] d, input logic [3:0] dpm);
        check({tag, "_min"}, {26'd0, minutes}, {26'd0, m});
        check({tag, "_sec"}, {26'd0, seconds}, {26'd0, s});
        check({tag, "_dig"}, {16'd0, digits}, {16'd0, d});
        check({tag, "_dpm"}, {28'd0, dp_mask}, {28'd0, dpm});
    endtask

    initial begin
        resetSW = 1'b1;
        AN = 8'hFF;
        CX = 8'hFF;
        repeat (3) cyc();
        resetSW = 1'b0;
        cyc();
        check_outputs("rst", 6'd0, 6'd0, 16'h0000, 4'b0000);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_err", {31'd0, seg_err}, 32'd0);
        check("rst_lost", {31'd0, scan_lost}, 32'd0);

        // 12:34 with dp on pos2
        show(8'hF7, cx(1, 1'b0), 10, 1);
        show(8'hFB, cx(2, 1'b1), 10, 1);
        show(8'hFD, cx(3, 1'b0), 10, 1);
        show(8'hFE, cx(4, 1'b0), 10, 1);
        check("t1_fv", fv_cnt, 32'd1);
        check("t1_err", err_cnt, 32'd0);
        check_outputs("t1", 6'd12, 6'd34, 16'h1234, 4'b0100);

        // short holds on pos3 must not be accepted
        show(8'hF7, cx(7, 1'b0), 3, 0);
        show(8'hF7, cx(9, 1'b0), 3, 1);
        show(8'hFB, cx(3, 1'b0), 10, 1);
        show(8'hFD, cx(4, 1'b0), 10, 1);
        show(8'hFE, cx(5, 1'b0), 10, 1);
        check("t2_nofv", fv_cnt, 32'd1);
        show(8'hF7, cx(2, 1'b0), 4, 4);
        check("t2_fv", fv_cnt, 32'd2);
        check_outputs("t2", 6'd23, 6'd45, 16'h2345, 4'b0000);

        // 75:20 has an out-of-range upper minute digit
        show(8'hF7, cx(7, 1'b0), 10, 1);
        show(8'hFB, cx(5, 1'b0), 10, 1);
        show(8'hFD, cx(2, 1'b0), 10, 1);
        show(8'hFE, cx(0, 1'b0), 10, 1);
        check("t4_err", err_cnt, 32'd1);
        check("t4_fv", fv_cnt, 32'd2);
        check_outputs("t4", 6'd23, 6'd45, 16'h2345, 4'b0000);

        // blank glyph on pos1 discards the partial frame
        show(8'hF7, cx(1, 1'b0), 10, 1);
        show(8'hFB, cx(2, 1'b0), 10, 1);
        show(8'hFD, 8'hFF, 10, 1);
        check("t3_err", err_cnt, 32'd2);
        show(8'hFD, cx(0, 1'b0), 10, 1);
        show(8'hFE, cx(0, 1'b0), 10, 1);
        check("t3_nofv", fv_cnt, 32'd2);
        show(8'hF7, cx(0, 1'b0), 10, 1);
        show(8'hFB, cx(0, 1'b0), 10, 1);
        check("t3_fv", fv_cnt, 32'd3);
        check_outputs("t3", 6'd0, 6'd0, 16'h0000, 4'b0000);

        // scan stops, then resumes with 59:59
        check("t5_live", {31'd0, scan_lost}, 32'd0);
        repeat (70) cyc();
        check("t5_lost", {31'd0, scan_lost}, 32'd1);
        show(8'hF7, cx(5, 1'b0), 10, 1);
        check("t5_relock", {31'd0, scan_lost}, 32'd0);
        show(8'hFB, cx(9, 1'b0), 10, 1);
        show(8'hFD, cx(5, 1'b0), 10, 1);
        show(8'hFE, cx(9, 1'b0), 10, 1);
        check("t5_fv", fv_cnt, 32'd4);
        check_outputs("t5", 6'd59, 6'd59, 16'h5959, 4'b0000);

        // reset after two digits
        show(8'hF7, cx(3, 1'b0), 10, 1);
        show(8'hFB, cx(1, 1'b0), 10, 1);
        resetSW = 1'b1;
        repeat (2) cyc();
        resetSW = 1'b0;
        cyc();
        check_outputs("t6_rst", 6'd0, 6'd0, 16'h0000, 4'b0000);
        check("t6_rst_fv", {31'd0, frame_valid}, 32'd0);
        check("t6_rst_err", {31'd0, seg_err}, 32'd0);
        check("t6_rst_lost", {31'd0, scan_lost}, 32'd0);
        show(8'hFD, cx(1, 1'b0), 10, 1);
        show(8'hFE, cx(5, 1'b0), 10, 1);
        check("t6_nofv", fv_cnt, 32'd4);
        show(8'hF7, cx(0, 1'b0), 10, 1);
        show(8'hFB, cx(8, 1'b0), 10, 1);
        check("t6_fv", fv_cnt, 32'd5);
        check("t6_err", err_cnt, 32'd2);
        check_outputs("t6", 6'd8, 6'd15, 16'h0815, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
